pattern_memory_arbiter: RTL and testbench
=========================================

# pattern_memory_arbiter

Shares the single 256×16 actuator pattern memory between two requesters: the host command path (read/write) and the playback sequencer (read-only). The block arbitrates between them with host priority and a starvation guard. It then sequences the memory's active-low enable, write and read strobes through a fixed-length access FSM and returns an acknowledge pulse and the read data to the winner. It sits between the command/playback logic and the memory macro pins.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- READ_LAT, 2, cycles from end of read strobe to data sample; legal range 1–7
- HOST_STREAK, 4, maximum consecutive host grants while playback waits; legal range 1–15

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable_sn  in  1  synchronous disable, active high
- host_req  in  1  host access request; level signal, held until host_ack
- host_write  in  1  1 = write, 0 = read; valid with host_req
- host_address  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse: host access complete
- play_req  in  1  playback read request; held until play_ack
- play_address  in  ADDR_W  playback address
- play_ack  out  1  one-cycle pulse: playback read complete
- read_data  out  DATA_W  last captured read data
- read_owner  out  1  owner of read_data: 0 = host, 1 = playback
- busy  out  1  FSM not in IDLE
- memory_enable_n  out  1  memory enable, active low
- memory_write_n  out  1  write strobe, active low
- memory_read_n  out  1  read strobe, active low
- memory_address  out  ADDR_W  latched access address
- memory_data_out  out  DATA_W  latched write data
- memory_data_in  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WR, RD, WAIT, DONE.
- IDLE: requests are sampled only in this state, and only with enable_sn=0.
  - If any request is present: select a winner; latch its address, write data, direction and owner.
  - Go to WR (host write) or RD (any read).
- Winner selection:
  - Host wins if only host_req is high.
  - Playback wins if only play_req is high.
  - If both are high: host wins unless streak == HOST_STREAK, in which case playback wins.
- Streak counter:
  - Increments on a host grant made while play_req is high.
  - Clears on any playback grant, or on a host grant made with play_req low.
  - Saturates at HOST_STREAK.
- WR: one cycle. memory_enable_n=0, memory_write_n=0. Next state DONE.
- RD: one cycle. memory_enable_n=0, memory_read_n=0. Next state WAIT. Wait counter is loaded with READ_LAT.
- WAIT: all strobes high. The wait counter decrements each cycle.
  - On the cycle the counter reaches 1: capture memory_data_in into read_data, update read_owner, go to DONE.
- DONE: one cycle. Pulse host_ack or play_ack for the latched owner. Next state IDLE.
- Requester handshake: the requester must drop its req in the cycle after it sees ack. A req still high in IDLE is treated as a new request.
- read_data and read_owner hold until the next completed read. Writes do not alter them.
- memory_address and memory_data_out hold their last latched values while in IDLE.
- enable_sn=1, in any state: next edge goes to IDLE.
  - All strobes high, no ack issued, streak cleared.
  - read_data is retained.
  - An access aborted this way is lost; its requester must re-request.
- Strobes are decoded from the registered state, so they are glitch-free and change only at clock edges.

## Timing
- Reset values: state IDLE, all strobes 1, host_ack=0, play_ack=0, busy=0, read_data=0, read_owner=0, memory_address=0, memory_data_out=0, streak=0, wait counter=0.
- Write latency: req sampled in IDLE at cycle 0 → WR strobe in cycle 1 → ack in cycle 2 → IDLE in cycle 3. One access every 3 cycles.
- Read latency: RD in cycle 1 → WAIT in cycles 2..1+READ_LAT → ack in cycle 2+READ_LAT.
  - read_data is valid in the ack cycle.
  - READ_LAT=2: ack in cycle 4.
- busy is high from cycle 1 through the DONE cycle, inclusive.
- Back-to-back accesses: at least one IDLE cycle separates them, so the memory sees a deasserted enable between accesses.
- enable_sn asserted during a WR or RD cycle: the strobe ends at that edge and is never extended.
- Asynchronous reset mid-access: strobes deassert immediately, without waiting for a clock edge.
- Simultaneous request and ack: a req arriving in the DONE cycle is not sampled until IDLE.

## Test plan
- Host write 0xA5A5 to address 0x12: memory_write_n low for exactly 1 cycle with memory_address=0x12 and memory_data_out=0xA5A5; host_ack in cycle 2.
- Playback read of address 0x40 with memory_data_in=0x1234 and READ_LAT=2: memory_read_n low in cycle 1; play_ack in cycle 4 with read_data=0x1234 and read_owner=1.
- Both requesters held continuously with HOST_STREAK=4: grant order H,H,H,H,P,H,H,H,H,P…; no playback wait exceeds 4 host accesses.
- enable_sn pulsed during WAIT of a host read: state returns to IDLE next edge, no host_ack, read_data unchanged, strobes high; a re-request completes normally.
- reset asserted mid-WR: memory_write_n and memory_enable_n go high without a clock edge; all outputs take their reset values.
- Host holds req through ack (protocol violation): a second identical access is issued after one IDLE cycle; no double ack within a single access.

Source files
------------

// File: rtl/pattern_memory_arbiter.sv
// pattern_memory_arbiter: shares one actuator pattern memory between
// the host command path and the playback sequencer.
module pattern_memory_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int READ_LAT    = 2,
    parameter int HOST_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_sn,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_address,
    output logic              play_ack,
    output logic [DATA_W-1:0] read_data,
    output logic              read_owner,
    output logic              busy,
    output logic              memory_enable_n,
    output logic              memory_write_n,
    output logic              memory_read_n,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    input  logic [DATA_W-1:0] memory_data_in
);

    localparam int CNT_W = 3;
    localparam int STK_W = 4;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(HOST_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [STK_W-1:0] streak;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc_write;
    logic             acc_owner;
    logic             grant;
    logic             grant_play;

    // winner selection: host first, playback once the host streak is spent
    always_comb begin
        grant      = (state == IDLE) && !enable_sn && (host_req || play_req);
        grant_play = play_req && (!host_req || (streak == STK_MAX));
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and strobe/ack decode from the registered state
    always_comb begin
        state_nx        = state;
        memory_enable_n = 1'b1;
        memory_write_n  = 1'b1;
        memory_read_n   = 1'b1;
        host_ack        = 1'b0;
        play_ack        = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = (!grant_play && host_write) ? WR : RD;
                end
            end
            WR: begin
                memory_enable_n = 1'b0;
                memory_write_n  = 1'b0;
                state_nx        = DONE;
            end
            RD: begin
                memory_enable_n = 1'b0;
                memory_read_n   = 1'b0;
                state_nx        = WAIT;
            end
            WAIT: begin
                if (wait_cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                host_ack = !acc_owner;
                play_ack = acc_owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (enable_sn) begin
            state_nx = IDLE;
        end
    end

    assign busy = (state != IDLE);

    // access latch, streak guard, read wait counter and read capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak          <= '0;
            wait_cnt        <= '0;
            acc_write       <= 1'b0;
            acc_owner       <= 1'b0;
            read_data       <= '0;
            read_owner      <= 1'b0;
            memory_address  <= '0;
            memory_data_out <= '0;
        end else if (enable_sn) begin
            streak <= '0;
        end else begin
            if (grant) begin
                acc_owner <= grant_play;
                acc_write <= !grant_play && host_write;
                if (grant_play) begin
                    memory_address <= play_address;
                    streak         <= '0;
                end else begin
                    memory_address  <= host_address;
                    memory_data_out <= host_wdata;
                    if (!play_req) begin
                        streak <= '0;
                    end else if (streak != STK_MAX) begin
                        streak <= streak + STK_W'(1);
                    end
                end
            end
            if (state == RD) begin
                wait_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
                if (wait_cnt == CNT_W'(1)) begin
                    read_data  <= memory_data_in;
                    read_owner <= acc_owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_memory_arbiter.sv
// tb_pattern_memory_arbiter: vector table plus multi-cycle corner
// sequences, with a scoreboard queue popped on every ack.
module tb_pattern_memory_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int HS = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable_sn;
    logic          host_req;
    logic          host_write;
    logic [AW-1:0] host_address;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          play_req;
    logic [AW-1:0] play_address;
    logic          play_ack;
    logic [DW-1:0] read_data;
    logic          read_owner;
    logic          busy;
    logic          memory_enable_n;
    logic          memory_write_n;
    logic          memory_read_n;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_data_out;
    logic [DW-1:0] memory_data_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          owner;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          owner;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
    } vec_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            wr_low = 0;
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];
    vec_t          tbl    [8];

    pattern_memory_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .READ_LAT(RL),
        .HOST_STREAK(HS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable_sn(enable_sn),
        .host_req(host_req),
        .host_write(host_write),
        .host_address(host_address),
        .host_wdata(host_wdata),
        .host_ack(host_ack),
        .play_req(play_req),
        .play_address(play_address),
        .play_ack(play_ack),
        .read_data(read_data),
        .read_owner(read_owner),
        .busy(busy),
        .memory_enable_n(memory_enable_n),
        .memory_write_n(memory_write_n),
        .memory_read_n(memory_read_n),
        .memory_address(memory_address),
        .memory_data_out(memory_data_out),
        .memory_data_in(memory_data_in)
    );

    always #5 clock = ~clock;

    // memory macro model
    always @(posedge clock) begin
        if (!memory_enable_n && !memory_write_n) begin
            mem[memory_address] <= memory_data_out;
        end
    end

    assign memory_data_in = mem[memory_address];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard pop on ack, strobe content and width checks
    always @(negedge clock) begin
        if (host_ack || play_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, host_ack, play_ack}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("both_acks", host_ack & play_ack, 0);
                chk("ack_owner", play_ack, mon_e.owner);
                if (!mon_e.write) begin
                    chk("read_data", read_data, mon_e.data);
                    chk("read_owner", read_owner, mon_e.owner);
                end
            end
        end
        if (!memory_write_n) begin
            wr_low++;
            if (sb.size() > 0) begin
                chk("wr_dir", sb[0].write, 1);
                chk("wr_addr", memory_address, sb[0].addr);
                chk("wr_data", memory_data_out, sb[0].data);
            end
        end else begin
            if (wr_low != 0) chk("wr_width", wr_low, 1);
            wr_low = 0;
        end
        if (!memory_read_n && sb.size() > 0) begin
            chk("rd_addr", memory_address, sb[0].addr);
        end
    end

    task automatic push_exp(input logic owner, input logic write,
                            input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        exp_t e;
        e.owner = owner;
        e.write = write;
        e.addr  = addr;
        e.data  = write ? wdata : shadow[addr];
        if (write) shadow[addr] = wdata;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit seen;
        push_exp(v.owner, v.write, v.addr, v.wdata);
        if (v.owner) begin
            play_req     = 1'b1;
            play_address = v.addr;
        end else begin
            host_req     = 1'b1;
            host_write   = v.write;
            host_address = v.addr;
            host_wdata   = v.wdata;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            seen = host_ack || play_ack;
        end
        chk("ack_latency", lat, v.lat);
        host_req = 1'b0;
        play_req = 1'b0;
        @(negedge clock);
        chk("idle_gap_busy", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem[8'h40]    = 16'h1234;
        shadow[8'h40] = 16'h1234;
        mem[8'h50]    = 16'hBEEF;
        shadow[8'h50] = 16'hBEEF;

        tbl[0] = '{1'b0, 1'b1, 8'h12, 16'hA5A5, 2};
        tbl[1] = '{1'b1, 1'b0, 8'h40, 16'h0000, RL + 2};
        tbl[2] = '{1'b0, 1'b0, 8'h12, 16'h0000, RL + 2};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 2};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 16'h0001, 2};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 16'h0000, RL + 2};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, RL + 2};
        tbl[7] = '{1'b1, 1'b0, 8'h12, 16'h0000, RL + 2};

        reset        = 1'b1;
        enable_sn    = 1'b0;
        host_req     = 1'b0;
        host_write   = 1'b0;
        host_address = '0;
        host_wdata   = '0;
        play_req     = 1'b0;
        play_address = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_strobes",
            {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        chk("rst_acks", {host_ack, play_ack}, 2'b00);
        chk("rst_read_data", read_data, 0);
        chk("rst_read_owner", read_owner, 0);
        chk("rst_mem_addr", memory_address, 0);
        chk("rst_mem_dout", memory_data_out, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
        end

        // both requesters held: H,H,H,H,P twice
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_exp(1'b1, 1'b0, 8'h40, 16'h0000);
            else push_exp(1'b0, 1'b1, 8'h20, 16'h5A5A);
        end
        host_req     = 1'b1;
        host_write   = 1'b1;
        host_address = 8'h20;
        host_wdata   = 16'h5A5A;
        play_req     = 1'b1;
        play_address = 8'h40;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("streak_drain", sb.size(), 0);
        host_req = 1'b0;
        play_req = 1'b0;
        repeat (3) @(negedge clock);

        // enable_sn abort during WAIT of a host read
        host_req     = 1'b1;
        host_write   = 1'b0;
        host_address = 8'h50;
        @(negedge clock);
        chk("abort_rd_strobe", memory_read_n, 0);
        @(negedge clock);
        chk("abort_in_wait", busy, 1);
        enable_sn = 1'b1;
        host_req  = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_strobes",
            {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        chk("abort_read_data", read_data, 16'h1234);
        chk("abort_read_owner", read_owner, 1);
        enable_sn = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("abort_no_ack", host_ack, 0);
        end
        run_vec('{1'b0, 1'b0, 8'h50, 16'h0000, RL + 2});

        // reset asserted while the write strobe is low
        host_req     = 1'b1;
        host_write   = 1'b1;
        host_address = 8'h33;
        host_wdata   = 16'h7777;
        @(negedge clock);
        chk("midwr_strobe", {memory_enable_n, memory_write_n}, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        chk("midwr_async_strobes",
            {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        chk("midwr_busy", busy, 0);
        chk("midwr_read_data", read_data, 0);
        chk("midwr_mem_addr", memory_address, 0);
        chk("midwr_mem_dout", memory_data_out, 0);
        host_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_vec('{1'b0, 1'b0, 8'h33, 16'h0000, RL + 2});

        // host holds req through ack: second access after one idle cycle
        push_exp(1'b0, 1'b1, 8'h60, 16'h1357);
        push_exp(1'b0, 1'b1, 8'h60, 16'h1357);
        host_req     = 1'b1;
        host_write   = 1'b1;
        host_address = 8'h60;
        host_wdata   = 16'h1357;
        n = 0;
        while (!host_ack && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("hold_first_lat", n, 2);
        gap = 0;
        do begin
            @(negedge clock);
            gap++;
        end while (!host_ack && gap < 20);
        chk("hold_ack_gap", gap, 3);
        host_req = 1'b0;
        @(negedge clock);
        chk("hold_ack_pulse", host_ack, 0);
        run_vec('{1'b0, 1'b0, 8'h60, 16'h0000, RL + 2});

        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
